// File: rtl/core_sim_ctrl.sv
// rtl/core_sim_ctrl.sv - run controller with programmable interrupt channels and cycle budget
//
// Purpose: counts run cycles for a core under test, ends the run on the core's
// completed flag or on exhaustion of MAX_CLOCKS, and drives NUM_CH interrupt
// lines that fire at programmable cycles in one-shot, periodic or level mode.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   cfg_we/cfg_ch/cfg_field   channel config write (0=start,1=width,2=period,3=mode)
//   cfg_wdata                 config data; mode bit0=enable, bit1=level
//   run                       level, starts and holds a run
//   completed                 core completion flag
//   intr_ack                  per-channel acknowledge for level mode
//   intr                      registered interrupt lines to the core
//   cycles                    current run cycle count
//   done / timeout            run ended by completed / by budget
//   intr_ovf                  sticky, trigger arrived while line high
//   fire_cnt                  packed per-channel rising-edge counts
module core_sim_ctrl #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 32,
    parameter int MAX_CLOCKS = 100000,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [1:0]              cfg_field,
    input  logic [CNT_W-1:0]        cfg_wdata,
    input  logic                    run,
    input  logic                    completed,
    input  logic [NUM_CH-1:0]       intr_ack,
    output logic [NUM_CH-1:0]       intr,
    output logic [CNT_W-1:0]        cycles,
    output logic                    done,
    output logic                    timeout,
    output logic [NUM_CH-1:0]       intr_ovf,
    output logic [NUM_CH*CNT_W-1:0] fire_cnt
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CLOCKS);
    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_start_run;
    logic              w_advance;
    logic [CNT_W-1:0]  w_cycles_nxt;

    logic [CNT_W-1:0]  r_cycles;
    logic [NUM_CH-1:0] r_intr;
    logic [NUM_CH-1:0] r_ovf;
    logic [CNT_W-1:0]  r_fire   [NUM_CH];
    logic [CNT_W-1:0]  r_start  [NUM_CH];
    logic [CNT_W-1:0]  r_width  [NUM_CH];
    logic [CNT_W-1:0]  r_period [NUM_CH];
    logic [1:0]        r_mode   [NUM_CH];
    logic [CNT_W-1:0]  r_next   [NUM_CH];
    logic [NUM_CH-1:0] r_nvld;
    logic [CNT_W-1:0]  r_wcnt   [NUM_CH];

    logic [NUM_CH-1:0] w_trig;
    logic [NUM_CH-1:0] w_intr_nxt;
    logic [NUM_CH-1:0] w_ovf_set;
    logic [CNT_W-1:0]  w_wcnt_nxt [NUM_CH];
    logic [CNT_W:0]    w_sum      [NUM_CH];
    logic              w_cfg_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_advance marks a RUN->RUN edge: the only edge where cycles counts and
    // channels may trigger. Any edge leaving RUN has it low, dropping intr.
    always_comb begin
        w_state_nxt = r_state;
        w_start_run = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt = S_RUN;
                    w_start_run = 1'b1;
                end
            end
            S_RUN: begin
                if (completed) begin
                    w_state_nxt = S_DONE;
                end else if (!run) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cycles == MAX_C) begin
                    w_state_nxt = S_TIMEOUT;
                end else begin
                    w_advance = 1'b1;
                end
            end
            S_DONE, S_TIMEOUT: begin
                if (!run) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_cycles_nxt = r_cycles + ONE;
    assign w_cfg_ok     = cfg_we && (r_state == S_IDLE) && (int'(cfg_ch) < NUM_CH);

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_trig[k]     = w_advance && r_nvld[k] && (w_cycles_nxt == r_next[k]);
            w_sum[k]      = {1'b0, r_next[k]} + {1'b0, r_period[k]};
            w_intr_nxt[k] = r_intr[k];
            w_wcnt_nxt[k] = r_wcnt[k];
            w_ovf_set[k]  = 1'b0;
            if (!w_advance) begin
                w_intr_nxt[k] = 1'b0;
                w_wcnt_nxt[k] = '0;
            end else if (r_mode[k][1]) begin
                // Level mode: a same-edge ack is consumed by the new trigger.
                if (w_trig[k]) begin
                    w_ovf_set[k]  = r_intr[k] && !intr_ack[k];
                    w_intr_nxt[k] = 1'b1;
                end else if (r_intr[k] && intr_ack[k]) begin
                    w_intr_nxt[k] = 1'b0;
                end
            end else begin
                // Pulse mode: r_wcnt holds the high cycles left, counting the current one.
                if (w_trig[k]) begin
                    w_ovf_set[k]  = r_intr[k];
                    w_intr_nxt[k] = 1'b1;
                    w_wcnt_nxt[k] = r_width[k];
                end else if (r_intr[k]) begin
                    if (r_wcnt[k] <= ONE) begin
                        w_intr_nxt[k] = 1'b0;
                        w_wcnt_nxt[k] = '0;
                    end else begin
                        w_wcnt_nxt[k] = r_wcnt[k] - ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cycles <= '0;
            r_intr   <= '0;
            r_ovf    <= '0;
            r_nvld   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_fire[k]   <= '0;
                r_start[k]  <= '0;
                r_width[k]  <= '0;
                r_period[k] <= '0;
                r_mode[k]   <= '0;
                r_next[k]   <= '0;
                r_wcnt[k]   <= '0;
            end
        end else begin
            if (w_cfg_ok) begin
                case (cfg_field)
                    2'd0:    r_start[cfg_ch]  <= cfg_wdata;
                    2'd1:    r_width[cfg_ch]  <= cfg_wdata;
                    2'd2:    r_period[cfg_ch] <= cfg_wdata;
                    default: r_mode[cfg_ch]   <= cfg_wdata[1:0];
                endcase
            end

            if (w_start_run) begin
                r_cycles <= '0;
            end else if (w_advance) begin
                r_cycles <= w_cycles_nxt;
            end

            r_intr <= w_intr_nxt;
            for (int k = 0; k < NUM_CH; k++) begin
                r_wcnt[k] <= w_wcnt_nxt[k];
                if (w_start_run) begin
                    r_ovf[k]  <= 1'b0;
                    r_fire[k] <= '0;
                    r_next[k] <= r_start[k];
                    // Zero start, disabled channel or zero-width pulse never triggers.
                    r_nvld[k] <= (r_start[k] != '0) && r_mode[k][0]
                                 && (r_mode[k][1] || (r_width[k] != '0));
                end else begin
                    if (w_ovf_set[k]) begin
                        r_ovf[k] <= 1'b1;
                    end
                    if (w_intr_nxt[k] && !r_intr[k] && !(&r_fire[k])) begin
                        r_fire[k] <= r_fire[k] + ONE;
                    end
                    if (w_trig[k]) begin
                        // One-shot (period 0) or wrap of next-trigger retires the channel.
                        if ((r_period[k] == '0) || w_sum[k][CNT_W]) begin
                            r_nvld[k] <= 1'b0;
                        end else begin
                            r_next[k] <= w_sum[k][CNT_W-1:0];
                        end
                    end
                end
            end
        end
    end

    assign intr     = r_intr;
    assign cycles   = r_cycles;
    assign done     = (r_state == S_DONE);
    assign timeout  = (r_state == S_TIMEOUT);
    assign intr_ovf = r_ovf;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fire
        assign fire_cnt[g*CNT_W +: CNT_W] = r_fire[g];
    end

endmodule

// File: tb/tb_core_sim_ctrl.sv
// tb/tb_core_sim_ctrl.sv - directed self-checking bench for core_sim_ctrl
module tb_core_sim_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_we;
    logic [0:0]  cfg_ch;
    logic [1:0]  cfg_field;
    logic [31:0] cfg_wdata;
    logic        run;
    logic        completed;
    logic [1:0]  intr_ack;

    logic [1:0]  intr_b, intr_s, ovf_b, ovf_s;
    logic [31:0] cycles_b, cycles_s;
    logic        done_b, done_s, timeout_b, timeout_s;
    logic [63:0] fire_b, fire_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    core_sim_ctrl #(.NUM_CH(2), .CNT_W(32), .MAX_CLOCKS(10000)) u_big (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .run(run),
        .completed(completed), .intr_ack(intr_ack), .intr(intr_b),
        .cycles(cycles_b), .done(done_b), .timeout(timeout_b),
        .intr_ovf(ovf_b), .fire_cnt(fire_b)
    );

    core_sim_ctrl #(.NUM_CH(2), .CNT_W(32), .MAX_CLOCKS(100)) u_small (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .run(run),
        .completed(completed), .intr_ack(intr_ack), .intr(intr_s),
        .cycles(cycles_s), .done(done_s), .timeout(timeout_s),
        .intr_ovf(ovf_s), .fire_cnt(fire_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int field, input int data);
        cfg_we    = 1'b1;
        cfg_ch    = 1'(ch);
        cfg_field = 2'(field);
        cfg_wdata = 32'(data);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic cfg_chan(input int ch, input int start, input int width,
                            input int period, input int mode);
        cfg_write(ch, 0, start);
        cfg_write(ch, 1, width);
        cfg_write(ch, 2, period);
        cfg_write(ch, 3, mode);
    endtask

    // After return both DUTs are in RUN with cycles == 0.
    task automatic run_start();
        run = 1'b1;
        tick();
    endtask

    task automatic run_stop();
        run       = 1'b0;
        completed = 1'b0;
        intr_ack  = '0;
        tick();
    endtask

    task automatic test_reset();
        int highs;
        rstn = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({intr_b, ovf_b, done_b, timeout_b, intr_s, ovf_s, done_s, timeout_s} !== '0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b required 0",
                     {intr_b, ovf_b, done_b, timeout_b, intr_s, ovf_s, done_s, timeout_s});
        end
        vectors++;
        if ({cycles_b, cycles_s, fire_b, fire_s} !== '0) begin
            miscompares++;
            $display("FAIL reset_counts: cycles %0d/%0d fire %h/%h required 0",
                     cycles_b, cycles_s, fire_b, fire_s);
        end
        tick();
        rstn = 1'b1;
        tick();
        cfg_chan(0, 5, 10, 0, 1);
        run_start();
        for (int i = 0; i < 20 && cycles_b != 7; i++) tick();
        vectors++;
        if (intr_b[0] !== 1'b1 || cycles_b !== 7) begin
            miscompares++;
            $display("FAIL reset_pre_intr: intr %b cycles %0d required 1 at 7", intr_b[0], cycles_b);
        end
        #3 rstn = 1'b0;
        #1;
        vectors++;
        if ({intr_b, ovf_b, done_b, timeout_b} !== '0 || cycles_b !== 0 || fire_b !== 0) begin
            miscompares++;
            $display("FAIL reset_async: intr %b cycles %0d fire %h required 0", intr_b, cycles_b, fire_b);
        end
        run = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        vectors++;
        if (cycles_b !== 0 || done_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: cycles %0d done %b required 0 0", cycles_b, done_b);
        end
        run_start();
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (intr_b !== 2'b00) highs++;
        end
        vectors++;
        if (highs != 0) begin
            miscompares++;
            $display("FAIL reset_cfg_cleared: %0d cycles with intr high, required 0", highs);
        end
        run_stop();
    endtask

    task automatic test_pulse();
        int bad, first_bad;
        logic [1:0] exp;
        cfg_chan(0, 500, 100, 0, 1);
        cfg_chan(1, 5000, 100, 0, 1);
        run_start();
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < 9000 && cycles_b != 8000; i++) begin
            tick();
            exp[0] = (cycles_b >= 500) && (cycles_b <= 599);
            exp[1] = (cycles_b >= 5000) && (cycles_b <= 5099);
            if (intr_b !== exp) begin
                bad++;
                if (first_bad < 0) first_bad = int'(cycles_b);
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL pulse_window: %0d bad cycles (first at %0d), required 0", bad, first_bad);
        end
        completed = 1'b1;
        tick();
        completed = 1'b0;
        vectors++;
        if (done_b !== 1'b1 || timeout_b !== 1'b0 || cycles_b !== 8000 || intr_b !== 2'b00) begin
            miscompares++;
            $display("FAIL pulse_done: done %b timeout %b cycles %0d intr %b required 1 0 8000 00",
                     done_b, timeout_b, cycles_b, intr_b);
        end
        vectors++;
        if (fire_b !== {32'd1, 32'd1}) begin
            miscompares++;
            $display("FAIL pulse_fire_cnt: got %h required 0000000100000001", fire_b);
        end
        run_stop();
        vectors++;
        if (done_b !== 1'b0 || cycles_b !== 8000 || fire_b !== {32'd1, 32'd1}) begin
            miscompares++;
            $display("FAIL pulse_retain: done %b cycles %0d fire %h required 0 8000 retained",
                     done_b, cycles_b, fire_b);
        end
    endtask

    task automatic test_periodic();
        int bad;
        logic exp;
        cfg_chan(0, 10, 3, 20, 1);
        cfg_chan(1, 0, 0, 0, 0);
        run_start();
        bad = 0;
        for (int i = 0; i < 300 && timeout_s !== 1'b1; i++) begin
            tick();
            if (timeout_s !== 1'b1) begin
                exp = (cycles_s >= 10) && (((cycles_s - 10) % 20) < 3);
                if (intr_s[0] !== exp) bad++;
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL periodic_window: %0d bad cycles, required 0", bad);
        end
        vectors++;
        if (timeout_s !== 1'b1 || done_s !== 1'b0 || cycles_s !== 100 || intr_s !== 2'b00) begin
            miscompares++;
            $display("FAIL periodic_timeout: timeout %b done %b cycles %0d intr %b required 1 0 100 00",
                     timeout_s, done_s, cycles_s, intr_s);
        end
        vectors++;
        if (fire_s[31:0] !== 32'd5) begin
            miscompares++;
            $display("FAIL periodic_fire_cnt: got %0d required 5", fire_s[31:0]);
        end
        run_stop();
        vectors++;
        if (timeout_s !== 1'b0) begin
            miscompares++;
            $display("FAIL periodic_clear: timeout %b required 0", timeout_s);
        end
    endtask

    task automatic test_level();
        int bad;
        int c;
        logic exp;
        cfg_chan(0, 10, 0, 5, 3);
        cfg_chan(1, 0, 0, 0, 0);
        run_start();
        bad = 0;
        for (int i = 0; i < 40 && cycles_b != 27; i++) begin
            tick();
            intr_ack = '0;
            c = int'(cycles_b);
            exp = ((c >= 10) && (c <= 22)) || (c >= 25);
            if (intr_b[0] !== exp) bad++;
            if (c == 22 || c == 23) intr_ack[0] = 1'b1;
            if (c == 14) begin
                vectors++;
                if (ovf_b[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL level_ovf_early: got %b required 0 at cycle 14", ovf_b[0]);
                end
            end
            if (c == 15) begin
                vectors++;
                if (ovf_b[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL level_ovf_set: got %b required 1 at cycle 15", ovf_b[0]);
                end
            end
            if (c == 24 || c == 25) begin
                vectors++;
                if (fire_b[31:0] !== 32'(c - 23)) begin
                    miscompares++;
                    $display("FAIL level_fire_cnt: got %0d required %0d at cycle %0d",
                             fire_b[31:0], c - 23, c);
                end
            end
        end
        vectors++;
        if (bad != 0 || cycles_b !== 27) begin
            miscompares++;
            $display("FAIL level_window: %0d bad cycles, end cycle %0d, required 0 and 27", bad, cycles_b);
        end
        run_stop();
        vectors++;
        if (intr_b !== 2'b00) begin
            miscompares++;
            $display("FAIL level_run_drop: intr %b required 00", intr_b);
        end
    endtask

    task automatic test_level_ack_trigger();
        int bad;
        int c;
        logic exp;
        cfg_chan(0, 10, 0, 5, 3);
        run_start();
        bad = 0;
        for (int i = 0; i < 30 && cycles_b != 16; i++) begin
            tick();
            intr_ack = '0;
            c = int'(cycles_b);
            exp = (c >= 10);
            if (intr_b[0] !== exp) bad++;
            if (c == 14) intr_ack[0] = 1'b1;
        end
        vectors++;
        if (bad != 0 || ovf_b[0] !== 1'b0 || fire_b[31:0] !== 32'd1) begin
            miscompares++;
            $display("FAIL level_ack_trig: bad %0d ovf %b fire %0d required 0 0 1",
                     bad, ovf_b[0], fire_b[31:0]);
        end
        run_stop();
    endtask

    task automatic test_pulse_overlap();
        int bad;
        int c;
        cfg_chan(0, 10, 8, 5, 1);
        run_start();
        bad = 0;
        for (int i = 0; i < 60 && cycles_b != 40; i++) begin
            tick();
            c = int'(cycles_b);
            if (intr_b[0] !== (c >= 10)) bad++;
            if (c == 14 && ovf_b[0] !== 1'b0) bad++;
            if (c >= 15 && ovf_b[0] !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL overlap_window: %0d bad cycles, required 0", bad);
        end
        vectors++;
        if (fire_b[31:0] !== 32'd1 || ovf_b[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL overlap_fire: fire %0d ovf %b required 1 1", fire_b[31:0], ovf_b[0]);
        end
        run_stop();
    endtask

    task automatic test_done_wins();
        cfg_chan(0, 0, 0, 0, 0);
        run_start();
        for (int i = 0; i < 150 && cycles_s != 100; i++) tick();
        completed = 1'b1;
        tick();
        completed = 1'b0;
        vectors++;
        if (done_s !== 1'b1 || timeout_s !== 1'b0 || cycles_s !== 100) begin
            miscompares++;
            $display("FAIL done_wins: done %b timeout %b cycles %0d required 1 0 100",
                     done_s, timeout_s, cycles_s);
        end
        run_stop();
    endtask

    task automatic test_cfg_during_run();
        int bad;
        int c;
        cfg_chan(0, 10, 4, 0, 1);
        for (int pass = 0; pass < 2; pass++) begin
            run_start();
            bad = 0;
            for (int i = 0; i < 40 && cycles_b != 20; i++) begin
                tick();
                cfg_we = 1'b0;
                c = int'(cycles_b);
                if (intr_b[0] !== ((c >= 10) && (c <= 13))) bad++;
                if (c == 3 && pass == 0) begin
                    cfg_we    = 1'b1;
                    cfg_ch    = 1'b0;
                    cfg_field = 2'd0;
                    cfg_wdata = 32'd5;
                end
            end
            vectors++;
            if (bad != 0 || fire_b[31:0] !== 32'd1) begin
                miscompares++;
                $display("FAIL cfg_in_run pass %0d: %0d bad cycles fire %0d required 0 and 1",
                         pass, bad, fire_b[31:0]);
            end
            run_stop();
        end
    endtask

    initial begin
        rstn      = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_field = '0;
        cfg_wdata = '0;
        run       = 1'b0;
        completed = 1'b0;
        intr_ack  = '0;
        test_reset();
        test_pulse();
        test_periodic();
        test_level();
        test_level_ack_trigger();
        test_pulse_overlap();
        test_done_wins();
        test_cfg_during_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
